// File: rtl/pdp11_alu.sv
// 1801VM1 datapath ALU: word/byte arithmetic, logic and shifts with PSW flags.
// Define ALU_COMB_OUT_EN for zero-latency combinational outputs.
module pdp11_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        ni,
  input  logic        ci,
  input  logic        mbyte,
  input  logic        add,
  input  logic        adc,
  input  logic        sub,
  input  logic        sbc,
  input  logic        inc2,
  input  logic        dec2,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  input  logic        com,
  input  logic        neg,
  input  logic        tst,
  input  logic        ror,
  input  logic        rol,
  input  logic        asr,
  input  logic        asl,
  input  logic        sxt,
  input  logic        mov,
  input  logic        cmp,
  input  logic        bit_,
  input  logic        bic,
  input  logic        bis,
  input  logic        exor,
  input  logic        swab,
  output logic [15:0] final_result,
  output logic [3:0]  ccmask,
  output logic [3:0]  final_flags
);

  typedef enum logic [4:0] {
    OP_NONE, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
    OP_INC2, OP_DEC2, OP_INC, OP_DEC, OP_CLR,
    OP_COM, OP_NEG, OP_TST, OP_ROR, OP_ROL,
    OP_ASR, OP_ASL, OP_SXT, OP_MOV, OP_CMP,
    OP_BIT, OP_BIC, OP_BIS, OP_EXOR, OP_SWAB
  } op_t;

  op_t         op;
  logic        byte_op, bm;
  logic [15:0] a, b, r, res;
  logic [16:0] s;
  logic        sa, sb, sr, zr, cy;
  logic        n, z, v, c;
  logic [3:0]  m, flags;

  // earlier strobes in the port list take precedence
  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      add:     op = OP_ADD;
      adc:     op = OP_ADC;
      sub:     op = OP_SUB;
      sbc:     op = OP_SBC;
      inc2:    op = OP_INC2;
      dec2:    op = OP_DEC2;
      inc:     op = OP_INC;
      dec:     op = OP_DEC;
      clr:     op = OP_CLR;
      com:     op = OP_COM;
      neg:     op = OP_NEG;
      tst:     op = OP_TST;
      ror:     op = OP_ROR;
      rol:     op = OP_ROL;
      asr:     op = OP_ASR;
      asl:     op = OP_ASL;
      sxt:     op = OP_SXT;
      mov:     op = OP_MOV;
      cmp:     op = OP_CMP;
      bit_:    op = OP_BIT;
      bic:     op = OP_BIC;
      bis:     op = OP_BIS;
      exor:    op = OP_EXOR;
      swab:    op = OP_SWAB;
      default: op = OP_NONE;
    endcase
  end

  always_comb begin
    byte_op = 1'b0;
    case (op)
      OP_ADC, OP_SBC, OP_INC, OP_DEC,
      OP_CLR, OP_COM, OP_NEG, OP_TST,
      OP_ROR, OP_ROL, OP_ASR, OP_ASL,
      OP_MOV, OP_CMP, OP_BIT, OP_BIC,
      OP_BIS:  byte_op = 1'b1;
      default: byte_op = 1'b0;
    endcase
  end

  assign bm = mbyte & byte_op;

  always_comb begin
    a  = bm ? {8'h00, in1[7:0]} : in1;
    b  = bm ? {8'h00, in2[7:0]} : in2;
    sa = bm ? in1[7] : in1[15];
    sb = bm ? in2[7] : in2[15];

    // byte operands are zero-extended, so carry/borrow lands in bit 8
    case (op)
      OP_ADD:  s = {1'b0, b} + {1'b0, a};
      OP_ADC:  s = {1'b0, b} + {16'd0, ci};
      OP_SUB:  s = {1'b0, b} - {1'b0, a};
      OP_SBC:  s = {1'b0, b} - {16'd0, ci};
      OP_INC2: s = {1'b0, b} + 17'd2;
      OP_DEC2: s = {1'b0, b} - 17'd2;
      OP_INC:  s = {1'b0, b} + 17'd1;
      OP_DEC:  s = {1'b0, b} - 17'd1;
      OP_NEG:  s = 17'd0 - {1'b0, b};
      OP_CMP:  s = {1'b0, a} - {1'b0, b};
      default: s = 17'd0;
    endcase
    cy = bm ? s[8] : s[16];

    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_INC2, OP_DEC2, OP_INC, OP_DEC,
      OP_NEG, OP_CMP: r = s[15:0];
      OP_CLR:  r = 16'd0;
      OP_COM:  r = ~b;
      OP_TST:  r = b;
      OP_ROR:  r = bm ? {8'h00, ci, in2[7:1]} : {ci, in2[15:1]};
      OP_ROL:  r = bm ? {8'h00, in2[6:0], ci} : {in2[14:0], ci};
      OP_ASR:  r = bm ? {8'h00, in2[7], in2[7:1]}
                      : {in2[15], in2[15:1]};
      OP_ASL:  r = bm ? {8'h00, in2[6:0], 1'b0} : {in2[14:0], 1'b0};
      OP_SXT:  r = {16{ni}};
      OP_MOV:  r = a;
      OP_BIT:  r = a & b;
      OP_BIC:  r = ~a & b;
      OP_BIS:  r = a | b;
      OP_EXOR: r = in1 ^ in2;
      OP_SWAB: r = {in2[7:0], in2[15:8]};
      default: r = in2;
    endcase

    sr = bm ? r[7] : r[15];
    zr = bm ? (r[7:0] == 8'h00) : (r == 16'h0000);
    n  = sr;
    z  = zr;
    v  = 1'b0;
    c  = 1'b0;
    m  = 4'b1111;

    case (op)
      OP_NONE: m = 4'b0000;
      OP_ADD: begin
        v = (sa == sb) && (sr != sb);
        c = cy;
      end
      OP_ADC: begin
        v = ~sb & sr;
        c = cy;
      end
      OP_SUB: begin
        v = (sa != sb) && (sr != sb);
        c = cy;
      end
      OP_SBC: begin
        v = sb & ~sr;
        c = cy;
      end
      OP_INC2, OP_DEC2: m = 4'b0000;
      OP_INC: begin
        v = ~sb & sr;
        m = 4'b1110;
      end
      OP_DEC: begin
        v = sb & ~sr;
        m = 4'b1110;
      end
      OP_COM: c = 1'b1;
      OP_NEG: begin
        v = sr & (bm ? (r[6:0] == 7'd0) : (r[14:0] == 15'd0));
        c = ~zr;
      end
      OP_ROR, OP_ASR: begin
        c = in2[0];
        v = sr ^ in2[0];
      end
      OP_ROL, OP_ASL: begin
        c = sb;
        v = sr ^ sb;
      end
      OP_SXT: begin
        z = ~ni;
        m = 4'b0110;
      end
      OP_MOV, OP_BIT, OP_BIC,
      OP_BIS, OP_EXOR: m = 4'b1110;
      OP_CMP: begin
        v = (sa != sb) && (sr != sa);
        c = cy;
      end
      OP_SWAB: begin
        n = r[7];
        z = (r[7:0] == 8'h00);
      end
      default: m = 4'b1111;
    endcase

    res = bm ? {(op == OP_MOV) ? {8{r[7]}} : in2[15:8], r[7:0]} : r;
    flags = {n, z, v, c} & m;
  end

`ifdef ALU_COMB_OUT_EN
  assign final_result = res;
  assign ccmask       = m;
  assign final_flags  = flags;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      final_result <= 16'd0;
      ccmask       <= 4'd0;
      final_flags  <= 4'd0;
    end else begin
      final_result <= res;
      ccmask       <= m;
      final_flags  <= flags;
    end
  end
`endif

endmodule

// File: tb/tb_pdp11_alu.sv
// Scoreboard bench for pdp11_alu: directed cases plus random stimulus
// checked against an integer-arithmetic reference model.
module tb_pdp11_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in1 = '0, in2 = '0;
  logic        ni = 1'b0, ci = 1'b0, mbyte = 1'b0;
  logic [23:0] st = '0;
  logic [15:0] final_result;
  logic [3:0]  ccmask, final_flags;

  localparam int ADD = 0, ADC = 1, SUB = 2, SBC = 3, INC2 = 4, DEC2 = 5;
  localparam int INC = 6, DEC = 7, CLR = 8, COM = 9, NEG = 10, TST = 11;
  localparam int ROR = 12, ROL = 13, ASR = 14, ASL = 15, SXT = 16;
  localparam int MOV = 17, CMP = 18, BIT = 19, BIC = 20, BIS = 21;
  localparam int EXOR = 22, SWAB = 23;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  msk;
    logic [3:0]  flg;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdp11_alu dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2),
    .ni(ni), .ci(ci), .mbyte(mbyte),
    .add(st[0]), .adc(st[1]), .sub(st[2]), .sbc(st[3]),
    .inc2(st[4]), .dec2(st[5]), .inc(st[6]), .dec(st[7]),
    .clr(st[8]), .com(st[9]), .neg(st[10]), .tst(st[11]),
    .ror(st[12]), .rol(st[13]), .asr(st[14]), .asl(st[15]),
    .sxt(st[16]), .mov(st[17]), .cmp(st[18]), .bit_(st[19]),
    .bic(st[20]), .bis(st[21]), .exor(st[22]), .swab(st[23]),
    .final_result(final_result), .ccmask(ccmask),
    .final_flags(final_flags)
  );

  function automatic int sgn(int x, int h);
    return (x >= h) ? x - 2 * h : x;
  endfunction

  function automatic bit ovf(int x, int h);
    return (x < -h) || (x >= h);
  endfunction

  // PDP-11 semantics with plain integers at width W (8 or 16)
  function automatic exp_t model(logic [15:0] ia, logic [15:0] ib,
                                 logic ini, logic ici, logic imb,
                                 logic [23:0] ist);
    exp_t e;
    int op, w, mx, h, av, bv, r, hi, ci_i;
    bit bmode, n, z, v, c, shv;
    bit [3:0] msk;
    op = -1;
    for (int i = 0; i < 24; i++)
      if (ist[i] && op < 0) op = i;
    e.tag = "rand";
    if (op < 0) begin
      e.res = ib;
      e.msk = 4'b0000;
      e.flg = 4'b0000;
      return e;
    end
    bmode = imb && (op inside {1, 3, [6:15], [17:21]});
    w = bmode ? 8 : 16;
    mx = (1 << w) - 1;
    h = 1 << (w - 1);
    av = int'(ia) & mx;
    bv = int'(ib) & mx;
    ci_i = ici ? 1 : 0;
    v = 0; c = 0; shv = 0; msk = 4'b1111; r = 0;
    case (op)
      ADD: begin r = bv + av; c = r > mx; v = ovf(sgn(bv, h) + sgn(av, h), h); end
      ADC: begin r = bv + ci_i; c = r > mx; v = ovf(sgn(bv, h) + ci_i, h); end
      SUB: begin r = bv - av; c = bv < av; v = ovf(sgn(bv, h) - sgn(av, h), h); end
      SBC: begin r = bv - ci_i; c = bv < ci_i; v = ovf(sgn(bv, h) - ci_i, h); end
      INC2: begin r = bv + 2; msk = 4'b0000; end
      DEC2: begin r = bv - 2; msk = 4'b0000; end
      INC: begin r = bv + 1; v = ovf(sgn(bv, h) + 1, h); msk = 4'b1110; end
      DEC: begin r = bv - 1; v = ovf(sgn(bv, h) - 1, h); msk = 4'b1110; end
      CLR: r = 0;
      COM: begin r = mx - bv; c = 1; end
      NEG: begin r = (-bv) & mx; v = (r == h); c = (r != 0); end
      TST: r = bv;
      ROR: begin r = (ici ? h : 0) + bv / 2; c = bv % 2; shv = 1; end
      ROL: begin r = bv * 2 + ci_i; c = bv >= h; shv = 1; end
      ASR: begin r = bv / 2 + ((bv >= h) ? h : 0); c = bv % 2; shv = 1; end
      ASL: begin r = bv * 2; c = bv >= h; shv = 1; end
      SXT: begin r = ini ? mx : 0; msk = 4'b0110; end
      MOV: begin r = av; msk = 4'b1110; end
      CMP: begin r = av - bv; c = av < bv; v = ovf(sgn(av, h) - sgn(bv, h), h); end
      BIT: begin r = av & bv; msk = 4'b1110; end
      BIC: begin r = (mx - av) & bv; msk = 4'b1110; end
      BIS: begin r = av | bv; msk = 4'b1110; end
      EXOR: begin r = av ^ bv; msk = 4'b1110; end
      default: r = (bv % 256) * 256 + bv / 256;
    endcase
    r = r & mx;
    n = r >= h;
    z = r == 0;
    if (shv) v = n ^ c;
    if (op == SWAB) begin
      n = (r % 256) >= 128;
      z = (r % 256) == 0;
    end
    if (op == SXT) z = !ini;
    if (bmode) begin
      hi = (op == MOV) ? (n ? 255 : 0) : int'(ib[15:8]);
      e.res = 16'(hi * 256 + r);
    end else begin
      e.res = 16'(r);
    end
    e.msk = msk;
    e.flg = {n, z, v, c} & msk;
    return e;
  endfunction

  task automatic drive(logic [15:0] a_, logic [15:0] b_, logic ni_,
                       logic ci_, logic mb_, logic [23:0] st_,
                       logic rst_);
    @(negedge clk);
    in1 = a_; in2 = b_; ni = ni_; ci = ci_;
    mbyte = mb_; st = st_; reset = rst_;
  endtask

  task automatic send(logic [15:0] a_, logic [15:0] b_, logic ni_,
                      logic ci_, logic mb_, logic [23:0] st_,
                      logic rst_);
    exp_t e;
    drive(a_, b_, ni_, ci_, mb_, st_, rst_);
    if (rst_) begin
      e.res = '0; e.msk = '0; e.flg = '0; e.tag = "rand_reset";
    end else begin
      e = model(a_, b_, ni_, ci_, mb_, st_);
    end
    q.push_back(e);
  endtask

  task automatic send_exp(logic [15:0] a_, logic [15:0] b_, logic ni_,
                          logic ci_, logic mb_, logic [23:0] st_,
                          logic rst_, logic [15:0] er, logic [3:0] em,
                          logic [3:0] ef, string tag);
    exp_t e;
    drive(a_, b_, ni_, ci_, mb_, st_, rst_);
    e.res = er; e.msk = em; e.flg = ef; e.tag = tag;
    q.push_back(e);
  endtask

  function automatic logic [23:0] one(int i);
    return 24'(1) << i;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'o077777;
      1: return 16'o100000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return {8'($urandom), ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80};
      default: return 16'($urandom);
    endcase
  endfunction

  // monitor: one registered result per cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (final_result !== e.res) begin
          failures++;
          $display("FAIL %s result got %06o exp %06o", e.tag, final_result, e.res);
        end
        checks++;
        if (ccmask !== e.msk) begin
          failures++;
          $display("FAIL %s ccmask got %b exp %b", e.tag, ccmask, e.msk);
        end
        checks++;
        if (final_flags !== e.flg) begin
          failures++;
          $display("FAIL %s flags got %b exp %b", e.tag, final_flags, e.flg);
        end
      end
    end
  end

  initial begin
    logic [23:0] s;
    int k;
    send_exp(0, 0, 0, 0, 0, 0, 1, 16'd0, 4'b0000, 4'b0000, "reset");
    send_exp(16'o000001, 16'o077777, 0, 0, 0, one(ADD), 0,
             16'o100000, 4'b1111, 4'b1010, "add_ovf");
    send_exp(16'd5, 16'd7, 0, 0, 0, one(CMP), 0,
             16'o177776, 4'b1111, 4'b1001, "cmp_borrow");
    send_exp(16'd5, 16'd7, 0, 0, 0, one(CMP), 1,
             16'd0, 4'b0000, 4'b0000, "reset_clears");
    send_exp(16'o000200, 16'd0, 0, 0, 1, one(MOV), 0,
             16'o177600, 4'b1110, 4'b1000, "movb_sext");
    send_exp(16'd0, 16'o012377, 0, 0, 1, one(INC), 0,
             16'o012000, 4'b1110, 4'b0100, "incb_wrap");
    send_exp(16'd0, 16'o000001, 0, 1, 0, one(ROR), 0,
             16'o100000, 4'b1111, 4'b1001, "ror_ci");
    send_exp(16'd0, 16'o040000, 0, 0, 0, one(ASL), 0,
             16'o100000, 4'b1111, 4'b1010, "asl_ovf");
    send_exp(16'd0, 16'o000377, 0, 0, 0, one(SWAB), 0,
             16'o177400, 4'b1111, 4'b0100, "swab_lo");
    send_exp(16'd0, 16'd0, 1, 0, 0, one(SXT), 0,
             16'o177777, 4'b0110, 4'b0000, "sxt_neg");
    send_exp(16'd3, 16'd4, 0, 0, 0, one(ADD) | one(INC), 0,
             16'd7, 4'b1111, 4'b0000, "add_over_inc");
    send_exp(16'd3, 16'o123456, 0, 0, 0, 24'd0, 0,
             16'o123456, 4'b0000, 4'b0000, "no_strobe");
    send_exp(16'd0, 16'o100000, 0, 0, 0, one(NEG), 0,
             16'o100000, 4'b1111, 4'b1011, "neg_min");
    send_exp(16'd0, 16'o000200, 0, 0, 1, one(DEC), 0,
             16'o000177, 4'b1110, 4'b0010, "decb_ovf");

    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      s = '0;
      if (k == 1) s = 24'($urandom);
      else if (k != 0) s = one($urandom_range(0, 23));
      send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom),
           s, ($urandom_range(0, 49) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
